// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - debounced keypad keystrokes and BCD multi-digit entry buffer

module keypad_entry #(
    parameter int MAX_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [3:0]                        number,
    input  logic                              pressed,
    output logic                              key_valid,
    output logic [3:0]                        key_code,
    output logic [4*MAX_DIGITS-1:0]           value,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
    output logic                              overflow,
    output logic                              entry_valid,
    output logic [4*MAX_DIGITS-1:0]           entry,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   entry_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam int VW = 4 * MAX_DIGITS;

    // Terminal count always fits in CW bits because DEBOUNCE_CYCLES-1 < 2**CW.
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DIGITS_MAX = DW'(MAX_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HOLD,
        RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept;

    // Debounce state and stability counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Press/release debounce: a key is accepted once, on the edge that completes a stable press.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = DEBOUNCE;
                    cnt_d   = CW'(1);
                end
            end
            DEBOUNCE: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    accept  = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (!pressed) begin
                    state_d = RELEASE;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE: begin
                if (pressed) begin
                    state_d = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Keystroke outputs and digit buffer, updated only on an accepted key.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid   <= 1'b0;
            key_code    <= '0;
            value       <= '0;
            digit_count <= '0;
            overflow    <= 1'b0;
            entry_valid <= 1'b0;
            entry       <= '0;
            entry_count <= '0;
        end else begin
            key_valid   <= accept;
            entry_valid <= 1'b0;
            if (accept) begin
                key_code <= number;
                if (number <= 4'd9) begin
                    if (digit_count < DIGITS_MAX) begin
                        value       <= (value << 4) | VW'(number);
                        digit_count <= digit_count + DW'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    case (number)
                        4'd10: begin
                            if (digit_count != '0) begin
                                value       <= value >> 4;
                                digit_count <= digit_count - DW'(1);
                            end
                            overflow <= 1'b0;
                        end
                        4'd14: begin
                            value       <= '0;
                            digit_count <= '0;
                            overflow    <= 1'b0;
                        end
                        4'd15: begin
                            if (digit_count != '0) begin
                                entry       <= value;
                                entry_count <= digit_count;
                                entry_valid <= 1'b1;
                                value       <= '0;
                                digit_count <= '0;
                                overflow    <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
